// File: rtl/axi_write_slave.sv
// -----------------------------------------------------------------------------
// axi_write_slave
//
// AXI4 write-channel slave responder. Accepts one burst at a time on AW/W,
// writes beats into a small 64-bit word memory under byte strobes, checks
// burst legality and WLAST placement, and answers on B with OKAY or SLVERR.
// A combinational side read port exposes memory contents for debug.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   axi_aw*                  write address channel (awready is registered)
//   axi_w*                   write data channel (wready is registered)
//   axi_b*                   write response channel (bvalid/bresp registered)
//   rd_idx / rd_data         debug read: rd_data = mem[rd_idx], combinational
// -----------------------------------------------------------------------------
module axi_write_slave #(
  parameter int AW    = 32,
  parameter int DW    = 64,
  parameter int DEPTH = 16,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   axi_awaddr,
  input  logic [7:0]      axi_awlen,
  input  logic [2:0]      axi_awsize,
  input  logic [1:0]      axi_awburst,
  input  logic            axi_awvalid,
  output logic            axi_awready,
  input  logic [DW-1:0]   axi_wdata,
  input  logic [DW/8-1:0] axi_wstrb,
  input  logic            axi_wlast,
  input  logic            axi_wvalid,
  output logic            axi_wready,
  output logic [1:0]      axi_bresp,
  output logic            axi_bvalid,
  input  logic            axi_bready,
  input  logic [IW-1:0]   rd_idx,
  output logic [DW-1:0]   rd_data
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_SLV   = 2'b10;

  state_t        state;
  logic [IW-1:0] idx;
  logic [7:0]    len;
  logic [7:0]    beat;
  logic [1:0]    burst;
  logic          err;

  logic [DW-1:0] mem [DEPTH];

  logic w_fire;
  logic last_beat;
  logic burst_end;
  logic err_end;
  logic mem_we;

  assign w_fire    = (state == S_DATA) && axi_wvalid && axi_wready;
  assign last_beat = (beat == len);
  // Burst ends on the counted last beat or on an early WLAST.
  assign burst_end = last_beat || axi_wlast;
  // The only clean ending is WLAST exactly on the counted last beat.
  assign err_end   = err || !(last_beat && axi_wlast);
  assign mem_we    = w_fire && !err;

  // Only the word-index bits of the address are meaningful.
  logic unused_addr;
  assign unused_addr = ^{axi_awaddr[AW-1:3+IW], axi_awaddr[2:0]};

  assign rd_data = mem[rd_idx];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      axi_awready <= 1'b0;
      axi_wready  <= 1'b0;
      axi_bvalid  <= 1'b0;
      axi_bresp   <= RESP_OKAY;
      idx         <= '0;
      len         <= '0;
      beat        <= '0;
      burst       <= '0;
      err         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (axi_awvalid && axi_awready) begin
            idx         <= axi_awaddr[3+IW-1:3];
            len         <= axi_awlen;
            burst       <= axi_awburst;
            // Only 8-byte beats and FIXED/INCR bursts are supported.
            err         <= (axi_awsize != 3'd3) || axi_awburst[1];
            beat        <= '0;
            axi_awready <= 1'b0;
            axi_wready  <= 1'b1;
            state       <= S_DATA;
          end else begin
            axi_awready <= 1'b1;
          end
        end

        S_DATA: begin
          if (w_fire) begin
            if (burst == BURST_INCR) idx <= idx + 1'b1;  // wraps at DEPTH
            beat <= beat + 8'd1;
            if (burst_end) begin
              err        <= err_end;
              axi_wready <= 1'b0;
              axi_bvalid <= 1'b1;
              axi_bresp  <= err_end ? RESP_SLV : RESP_OKAY;
              state      <= S_RESP;
            end
          end
        end

        S_RESP: begin
          if (axi_bready) begin
            axi_bvalid <= 1'b0;
            state      <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the memory is reset explicitly because the bench relies on every
  // word reading back as zero after reset; this forces flops, not a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (mem_we) begin
      for (int b = 0; b < DW/8; b++) begin
        if (axi_wstrb[b]) mem[idx][8*b +: 8] <= axi_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_write_slave.sv
module tb_axi_write_slave;

  localparam int AW    = 32;
  localparam int DW    = 64;
  localparam int DEPTH = 16;
  localparam int IW    = 4;
  localparam int LIMIT = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] axi_awaddr;
  logic [7:0]    axi_awlen;
  logic [2:0]    axi_awsize;
  logic [1:0]    axi_awburst;
  logic          axi_awvalid;
  logic          axi_awready;
  logic [DW-1:0] axi_wdata;
  logic [7:0]    axi_wstrb;
  logic          axi_wlast;
  logic          axi_wvalid;
  logic          axi_wready;
  logic [1:0]    axi_bresp;
  logic          axi_bvalid;
  logic          axi_bready;
  logic [IW-1:0] rd_idx;
  logic [DW-1:0] rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axi_write_slave #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
    .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .rd_idx(rd_idx), .rd_data(rd_data)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_mem(input string tag, input int i, input logic [63:0] exp);
    rd_idx = IW'(i);
    #1;
    check(tag, rd_data, exp);
  endtask

  // Called at a negedge; returns at the negedge after the AW handshake.
  task automatic aw_xfer(input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    axi_awaddr = addr; axi_awlen = len; axi_awsize = size; axi_awburst = burst;
    axi_awvalid = 1'b1;
    while (!axi_awready && n < LIMIT) begin @(negedge clk); n++; end
    check("aw_ready_wait", axi_awready, 1'b1);
    @(negedge clk);
    axi_awvalid = 1'b0;
    check("aw_drop_ready", axi_awready, 1'b0);
    check("aw_to_wready", axi_wready, 1'b1);
  endtask

  // Called at a negedge; returns at the negedge after the W handshake.
  task automatic w_beat(input logic [63:0] data, input logic [7:0] strb, input logic last);
    int n = 0;
    axi_wdata = data; axi_wstrb = strb; axi_wlast = last; axi_wvalid = 1'b1;
    while (!axi_wready && n < LIMIT) begin @(negedge clk); n++; end
    check("w_ready_wait", axi_wready, 1'b1);
    @(negedge clk);
    axi_wvalid = 1'b0; axi_wlast = 1'b0;
  endtask

  // Expects bvalid already high; completes B and checks the return to awready.
  task automatic b_xfer(input string tag, input logic [1:0] resp);
    check({tag, "_bvalid"}, axi_bvalid, 1'b1);
    check({tag, "_bresp"}, axi_bresp, resp);
    check({tag, "_wready_low"}, axi_wready, 1'b0);
    axi_bready = 1'b1;
    @(negedge clk);
    axi_bready = 1'b0;
    check({tag, "_bvalid_drop"}, axi_bvalid, 1'b0);
    check({tag, "_awready_wait1"}, axi_awready, 1'b0);
    @(negedge clk);
    check({tag, "_awready_back"}, axi_awready, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    axi_awaddr = '0; axi_awlen = '0; axi_awsize = '0; axi_awburst = '0; axi_awvalid = 1'b0;
    axi_wdata = '0; axi_wstrb = '0; axi_wlast = 1'b0; axi_wvalid = 1'b0;
    axi_bready = 1'b0; rd_idx = '0;

    // Reset release
    repeat (3) @(negedge clk);
    check("rst_awready", axi_awready, 1'b0);
    check("rst_wready", axi_wready, 1'b0);
    check("rst_bvalid", axi_bvalid, 1'b0);
    check("rst_bresp", axi_bresp, 2'b00);
    rst = 1'b0;
    axi_wvalid = 1'b1;   // early W must not be accepted
    @(negedge clk);
    check("rel_awready", axi_awready, 1'b1);
    check("rel_w_before_aw", axi_wready, 1'b0);
    axi_wvalid = 1'b0;
    for (int i = 0; i < DEPTH; i++) chk_mem("rst_mem", i, 64'h0);
    @(negedge clk);

    // Single beat INCR at idx 3
    aw_xfer(32'h18, 8'd0, 3'd3, 2'b01);
    w_beat(64'h1122_3344_5566_7788, 8'hFF, 1'b1);
    b_xfer("single", 2'b00);
    chk_mem("single_mem3", 3, 64'h1122_3344_5566_7788);

    // INCR wrap 14,15,0,1 with partial strobes on beat 2 and a 2-cycle gap
    aw_xfer(32'h70, 8'd3, 3'd3, 2'b01);
    w_beat(64'hD0D0_D0D0_D0D0_D0D0, 8'hFF, 1'b0);
    repeat (2) @(negedge clk);
    check("gap_wready", axi_wready, 1'b1);
    w_beat(64'hD1D1_D1D1_D1D1_D1D1, 8'hFF, 1'b0);
    w_beat(64'h0123_4567_89AB_CDEF, 8'h0F, 1'b0);
    w_beat(64'hD3D3_D3D3_D3D3_D3D3, 8'hFF, 1'b1);
    b_xfer("wrap", 2'b00);
    chk_mem("wrap_mem14", 14, 64'hD0D0_D0D0_D0D0_D0D0);
    chk_mem("wrap_mem15", 15, 64'hD1D1_D1D1_D1D1_D1D1);
    chk_mem("wrap_mem0", 0, 64'h0000_0000_89AB_CDEF);
    chk_mem("wrap_mem1", 1, 64'hD3D3_D3D3_D3D3_D3D3);
    chk_mem("wrap_mem2", 2, 64'h0);

    // FIXED burst at idx 1: last beat wins
    @(negedge clk);
    aw_xfer(32'h08, 8'd2, 3'd3, 2'b00);
    w_beat(64'hAAAA_0000_0000_000A, 8'hFF, 1'b0);
    w_beat(64'hBBBB_0000_0000_000B, 8'hFF, 1'b0);
    w_beat(64'hCCCC_0000_0000_000C, 8'hFF, 1'b1);
    b_xfer("fixed", 2'b00);
    chk_mem("fixed_mem1", 1, 64'hCCCC_0000_0000_000C);
    chk_mem("fixed_mem2", 2, 64'h0);
    chk_mem("fixed_mem0", 0, 64'h0000_0000_89AB_CDEF);

    // Bad size: data discarded, SLVERR
    @(negedge clk);
    aw_xfer(32'h20, 8'd1, 3'd2, 2'b01);
    w_beat(64'h4444_4444_4444_4444, 8'hFF, 1'b0);
    w_beat(64'h5555_5555_5555_5555, 8'hFF, 1'b1);
    b_xfer("badsize", 2'b10);
    chk_mem("badsize_mem4", 4, 64'h0);
    chk_mem("badsize_mem5", 5, 64'h0);

    // WRAP burst type: SLVERR
    @(negedge clk);
    aw_xfer(32'h28, 8'd0, 3'd3, 2'b10);
    w_beat(64'h5A5A_5A5A_5A5A_5A5A, 8'hFF, 1'b1);
    b_xfer("wrapburst", 2'b10);
    chk_mem("wrapburst_mem5", 5, 64'h0);

    // Early WLAST on beat 1 of 4: burst ends after 2 beats
    @(negedge clk);
    aw_xfer(32'h30, 8'd3, 3'd3, 2'b01);
    w_beat(64'h6666_6666_6666_6666, 8'hFF, 1'b0);
    w_beat(64'h7777_7777_7777_7777, 8'hFF, 1'b1);
    check("early_no_more_beats", axi_wready, 1'b0);
    b_xfer("early", 2'b10);
    chk_mem("early_mem6", 6, 64'h6666_6666_6666_6666);

    // Missing WLAST on the last beat
    @(negedge clk);
    aw_xfer(32'h40, 8'd1, 3'd3, 2'b01);
    w_beat(64'h8888_8888_8888_8888, 8'hFF, 1'b0);
    w_beat(64'h9999_9999_9999_9999, 8'hFF, 1'b0);
    b_xfer("nolast", 2'b10);

    // B backpressure: response held, no new AW accepted
    @(negedge clk);
    aw_xfer(32'h48, 8'd0, 3'd3, 2'b01);
    w_beat(64'hFEED_FACE_CAFE_BEEF, 8'hFF, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("bp_bvalid", axi_bvalid, 1'b1);
      check("bp_bresp", axi_bresp, 2'b00);
      check("bp_awready", axi_awready, 1'b0);
      @(negedge clk);
    end
    b_xfer("bp", 2'b00);
    chk_mem("bp_mem9", 9, 64'hFEED_FACE_CAFE_BEEF);

    // Reset mid-DATA, then a fresh burst
    @(negedge clk);
    aw_xfer(32'h50, 8'd3, 3'd3, 2'b01);
    w_beat(64'h1010_1010_1010_1010, 8'hFF, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_wready", axi_wready, 1'b0);
    check("midrst_bvalid", axi_bvalid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    chk_mem("midrst_mem3", 3, 64'h0);
    @(negedge clk);
    check("midrst_no_stale_b", axi_bvalid, 1'b0);
    aw_xfer(32'h10, 8'd0, 3'd3, 2'b01);
    w_beat(64'h0BAD_F00D_0BAD_F00D, 8'hFF, 1'b1);
    b_xfer("post_rst", 2'b00);
    chk_mem("post_rst_mem2", 2, 64'h0BAD_F00D_0BAD_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_write_slave.md
Name: axi_write_slave

Overview:
AXI4 write-channel slave responder that sits directly downstream of the AXI master write channel (FSM/ILA master models) and consumes its AW/W channels and produces the B channel. It accepts one burst at a time, writes beats into a small internal 64-bit word memory with byte strobes, checks burst legality and WLAST placement, and returns OKAY or SLVERR. A side read port exposes memory contents to the verification bench.

Parameters:
AW, 32, address width
DW, 64, data width; fixed at 64, strobe width DW/8 = 8
DEPTH, 16, number of 64-bit memory words; power of two, index width IW = log2(DEPTH)

Ports:
clk  in  1  global clock, all logic on rising edge
rst  in  1  reset, asynchronous and active-high
axi_awaddr  in  AW  burst start address (byte address)
axi_awlen  in  8  beats minus one
axi_awsize  in  3  bytes per beat, log2
axi_awburst  in  2  burst type
axi_awvalid  in  1  address valid
axi_awready  out  1  address ready
axi_wdata  in  64  write data
axi_wstrb  in  8  byte strobes
axi_wlast  in  1  last beat flag
axi_wvalid  in  1  data valid
axi_wready  out  1  data ready
axi_bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR
axi_bvalid  out  1  response valid
axi_bready  in  1  response ready
rd_idx  in  IW  debug read word index
rd_data  out  64  mem[rd_idx], combinational

Behaviour:
- Reset, async and active-high, applies while rst=1.
  - State goes to IDLE.
  - axi_awready=0, axi_wready=0, axi_bvalid=0, axi_bresp=2'b00.
  - All memory words are 0. Beat counter, length, index and error flag are 0.
- Reset mid-burst aborts the burst. No B response is issued for it.
- All handshake outputs are registered. States are IDLE, DATA, RESP.
- IDLE:
  - axi_awready rises 1 cycle after entering IDLE, including the first cycle after rst deasserts.
  - On axi_awvalid && axi_awready, latch:
    - idx = axi_awaddr[3+IW-1:3]
    - len = axi_awlen
    - burst = axi_awburst
    - err = (axi_awsize != 3) || (axi_awburst not in {2'b00 FIXED, 2'b01 INCR})
  - Clear the beat counter. Next cycle: axi_awready=0, axi_wready=1, state goes to DATA.
  - axi_awaddr[2:0] is ignored; accesses are word-aligned.
- DATA, on each axi_wvalid && axi_wready:
  - If err=0, for each bit b with axi_wstrb[b]=1: mem[idx][8b+7:8b] = axi_wdata byte b. Unstrobed bytes are unchanged.
  - If err=1, the data is discarded.
  - INCR advances idx = idx+1 modulo DEPTH (wraps DEPTH-1 to 0). FIXED keeps idx.
  - Beat counter increments (8-bit, compared to len).
  - If beat == len: err |= ~axi_wlast.
  - If beat < len and axi_wlast=1: err=1 and the burst ends immediately. Remaining beats are not accepted.
  - When the burst ends (last counted beat or early WLAST): next cycle axi_wready=0, axi_bvalid=1, axi_bresp = err ? 2'b10 : 2'b00, state goes to RESP.
  - axi_wready stays high between beats. W beats arriving before the AW handshake are not accepted (axi_wready=0).
- RESP:
  - axi_bvalid and axi_bresp are held stable until axi_bready.
  - On axi_bvalid && axi_bready: next cycle axi_bvalid=0, state goes to IDLE; axi_awready=1 the cycle after that.
- Latency:
  - AW handshake to first possible W handshake: 1 cycle.
  - Last W handshake to bvalid: 1 cycle.
  - B handshake to awready: 2 cycles.
- Only one outstanding burst; no ID support.
- Maximum burst length is 256 beats. Beats beyond DEPTH wrap and overwrite earlier words.
- A memory write and an rd_data read of the same index in the same cycle returns the old value.

Test Plan:
- Reset release: hold rst 3 cycles, release -> all outputs 0 during reset; awready=1 on 1st cycle after release; rd_data=0 for every index.
- Single beat: awaddr=0x18, len=0, size=3, burst=INCR; wdata=0x1122334455667788, wstrb=0xFF, wlast=1 -> mem[3]=0x1122334455667788; bvalid 1 cycle after W handshake; bresp=00.
- INCR burst with wrap and partial strobes: awaddr=0x70 (idx 14), len=3; beats D0..D3 with wstrb=0x0F on beat 2; 2-cycle wvalid gap before beat 1 -> mem[14]=D0, mem[15]=D1, mem[0] low 4 bytes only, mem[1]=D3; bresp=00.
- FIXED burst: awaddr=0x08, len=2, burst=FIXED, beats A,B,C -> mem[1]=C only; bresp=00.
- Errors:
  - awsize=2, len=1, 2 beats -> memory unchanged; bresp=10.
  - burst=WRAP -> memory unchanged; bresp=10.
  - len=3 with wlast on beat 1 -> only 2 beats accepted; bresp=10.
  - len=1 with wlast=0 on beat 1 -> bresp=10.
- Backpressure and reset: hold bready=0 for 5 cycles -> bvalid/bresp stable, awready=0 throughout. Assert rst mid-DATA, then start a new burst -> no stale bvalid; new burst completes with OKAY.
